// File: rtl/vadd_float_ctrl_pkg.sv
// vadd_float_ctrl_pkg: register map, FSM state types and CTRL bit positions for the vadd_float control slave.
package vadd_float_ctrl_pkg;

    localparam logic [5:0] ADDR_CTRL   = 6'h00;
    localparam logic [5:0] ADDR_GIE    = 6'h04;
    localparam logic [5:0] ADDR_IER    = 6'h08;
    localparam logic [5:0] ADDR_ISR    = 6'h0C;
    localparam logic [5:0] ADDR_XFER   = 6'h10;
    localparam logic [5:0] ADDR_PTR_LO = 6'h18;
    localparam logic [5:0] ADDR_PTR_HI = 6'h1C;

    localparam int CTRL_START = 0;
    localparam int CTRL_DONE  = 1;
    localparam int CTRL_IDLE  = 2;
    localparam int CTRL_READY = 3;
    localparam int CTRL_AUTO  = 7;

    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data,
                                               input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{strb[i]}};
        return (old & ~m) | (data & m);
    endfunction

endpackage

// File: rtl/vadd_float_control_s_axi_if.sv
// vadd_float_control_s_axi_if: AXI4-Lite control bus bundle with master/slave views.
interface vadd_float_control_s_axi_if #(parameter int AW = 12);
    logic          awvalid;
    logic          awready;
    logic [AW-1:0] awaddr;
    logic          wvalid;
    logic          wready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          bvalid;
    logic          bready;
    logic [1:0]    bresp;
    logic          arvalid;
    logic          arready;
    logic [AW-1:0] araddr;
    logic          rvalid;
    logic          rready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/vadd_float_control_s_axi.sv
// vadd_float_control_s_axi: AXI4-Lite register file and ap_ctrl_hs handshake for vadd_float.
// Interrupt registers (GIE/IER/ISR) exist only when VADD_FLOAT_IRQ_EN is defined.
module vadd_float_control_s_axi
    import vadd_float_ctrl_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                              ap_clk,
    input  logic                              areset,
    vadd_float_control_s_axi_if.slave         s_axi_control,
    output logic                              interrupt,
    output logic                              ap_start,
    input  logic                              ap_done,
    input  logic                              ap_idle,
    input  logic                              ap_ready,
    output logic [31:0]                       ctrl_xfer_size_in_bytes,
    output logic [63:0]                       axi00_ptr0
);

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;
    logic [5:0] waddr;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [31:0] rmux, ctrl_word, xfer, ptr_lo, ptr_hi;
    logic auto_restart, done_bit, ready_bit, idle_bit;
    logic w_hs, ar_hs, rd_ctrl, wr_ctrl, wr_xfer, wr_lo, wr_hi;

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    always_comb begin
        wr_next = (wr_state == WR_IDLE && s_axi_control.awvalid) ? WR_DATA :
                  (wr_state == WR_DATA && s_axi_control.wvalid)  ? WR_RESP :
                  (wr_state == WR_RESP && s_axi_control.bready)  ? WR_IDLE : wr_state;
        rd_next = (rd_state == RD_IDLE && s_axi_control.arvalid) ? RD_DATA :
                  (rd_state == RD_DATA && s_axi_control.rready)  ? RD_IDLE : rd_state;
    end

    // Ready outputs are masked by reset so the bus sees them low during the reset cycle itself.
    always_comb begin
        s_axi_control.awready = wr_state == WR_IDLE && !areset;
        s_axi_control.wready  = wr_state == WR_DATA;
        s_axi_control.bvalid  = wr_state == WR_RESP;
        s_axi_control.bresp   = 2'b00;
        s_axi_control.arready = rd_state == RD_IDLE && !areset;
        s_axi_control.rvalid  = rd_state == RD_DATA;
        s_axi_control.rdata   = rdata_q;
        s_axi_control.rresp   = 2'b00;
    end

    assign w_hs    = s_axi_control.wvalid && s_axi_control.wready;
    assign ar_hs   = s_axi_control.arvalid && s_axi_control.arready;
    assign rd_ctrl = ar_hs && s_axi_control.araddr[5:0] == ADDR_CTRL;
    assign wr_ctrl = w_hs && waddr == ADDR_CTRL && s_axi_control.wstrb[0];
    assign wr_xfer = w_hs && waddr == ADDR_XFER;
    assign wr_lo   = w_hs && waddr == ADDR_PTR_LO;
    assign wr_hi   = w_hs && waddr == ADDR_PTR_HI;

    always_ff @(posedge ap_clk) begin
        if (areset) waddr <= '0;
        else if (s_axi_control.awvalid && s_axi_control.awready) waddr <= s_axi_control.awaddr[5:0];
    end

    // Pulses set the sticky status bits in the same cycle a CTRL read clears them; the set wins.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            auto_restart <= 1'b0;
            ap_start     <= 1'b0;
            done_bit     <= 1'b0;
            ready_bit    <= 1'b0;
            idle_bit     <= 1'b0;
            xfer         <= '0;
            ptr_lo       <= '0;
            ptr_hi       <= '0;
        end else begin
            auto_restart <= wr_ctrl ? s_axi_control.wdata[CTRL_AUTO] : auto_restart;
            ap_start     <= (wr_ctrl && s_axi_control.wdata[CTRL_START]) ||
                            (ap_start && !(ap_ready && !auto_restart));
            done_bit     <= ap_done || (done_bit && !rd_ctrl);
            ready_bit    <= ap_ready || (ready_bit && !rd_ctrl);
            idle_bit     <= ap_idle;
            xfer         <= wr_xfer ? apply_strb(xfer, s_axi_control.wdata, s_axi_control.wstrb) : xfer;
            ptr_lo       <= wr_lo ? apply_strb(ptr_lo, s_axi_control.wdata, s_axi_control.wstrb) : ptr_lo;
            ptr_hi       <= wr_hi ? apply_strb(ptr_hi, s_axi_control.wdata, s_axi_control.wstrb) : ptr_hi;
        end
    end

`ifdef VADD_FLOAT_IRQ_EN
    logic gie, irq;
    logic [1:0] ier, isr;
    logic wr_isr;

    assign wr_isr = w_hs && waddr == ADDR_ISR && s_axi_control.wstrb[0];

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            gie <= 1'b0;
            ier <= '0;
            isr <= '0;
            irq <= 1'b0;
        end else begin
            gie    <= (w_hs && waddr == ADDR_GIE && s_axi_control.wstrb[0]) ? s_axi_control.wdata[0] : gie;
            ier    <= (w_hs && waddr == ADDR_IER && s_axi_control.wstrb[0]) ? s_axi_control.wdata[1:0] : ier;
            isr[0] <= (ier[0] && ap_done)  ? 1'b1 : wr_isr ? isr[0] ^ s_axi_control.wdata[0] : isr[0];
            isr[1] <= (ier[1] && ap_ready) ? 1'b1 : wr_isr ? isr[1] ^ s_axi_control.wdata[1] : isr[1];
            irq    <= gie && |isr;
        end
    end

    assign interrupt = irq;
`else
    assign interrupt = 1'b0;
`endif

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_START] = ap_start;
        ctrl_word[CTRL_DONE]  = done_bit;
        ctrl_word[CTRL_IDLE]  = idle_bit;
        ctrl_word[CTRL_READY] = ready_bit;
        ctrl_word[CTRL_AUTO]  = auto_restart;
    end

    always_comb begin
        rmux = '0;
        case (s_axi_control.araddr[5:0])
            ADDR_CTRL:   rmux = ctrl_word;
`ifdef VADD_FLOAT_IRQ_EN
            ADDR_GIE:    rmux = {31'b0, gie};
            ADDR_IER:    rmux = {30'b0, ier};
            ADDR_ISR:    rmux = {30'b0, isr};
`endif
            ADDR_XFER:   rmux = xfer;
            ADDR_PTR_LO: rmux = ptr_lo;
            ADDR_PTR_HI: rmux = ptr_hi;
            default:     rmux = '0;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (areset) rdata_q <= '0;
        else if (ar_hs) rdata_q <= rmux;
    end

    assign ctrl_xfer_size_in_bytes = xfer;
    assign axi00_ptr0 = {ptr_hi, ptr_lo};

endmodule
